// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table.
// Counter encoding: 0 = strong not-taken ... 2^CTR_W-1 = strong taken;
// the prediction is the counter MSB. Counters reset to strong not-taken.
package bp_pkg;

  localparam int BP_MODE_BIMODAL = 0;
  localparam int BP_MODE_GSHARE  = 1;

  // Reset / clear value of every counter: strong not-taken.
  localparam logic [3:0] BP_CTR_RST = 4'd0;

  // Saturating step of a counter up to 4 bits wide; ctr_w selects the width.
  function automatic logic [3:0] bp_sat_next(input logic [3:0] ctr,
                                             input logic       taken,
                                             input int unsigned ctr_w);
    logic [3:0] max;
    max = 4'((5'd1 << ctr_w) - 5'd1);
    if (taken) return (ctr == max) ? ctr : ctr + 4'd1;
    else       return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One CTR_W-bit saturating counter.
// Ports: clk, rst (async high), clr_i (sync clear), en_i (step enable),
//        taken_i (step direction), ctr_o (current count).
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o
);

  logic [CTR_W-1:0] ctr_q, ctr_d;

  assign ctr_d = CTR_W'(bp_sat_next(4'(ctr_q), taken_i, CTR_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ctr_q <= CTR_W'(BP_CTR_RST);
    else if (clr_i) ctr_q <= CTR_W'(BP_CTR_RST);
    else if (en_i)  ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table: ENTRIES saturating counters, bimodal or gshare index.
// Ports:
//   clk, rst (async high), clr (sync clear of table/history/stats)
//   lkp_valid, lkp_pc -> lkp_taken, lkp_idx   combinational lookup
//   upd_valid, upd_idx, upd_taken, upd_pred    resolve/training port
//   ghr (LSB = newest outcome), mispred_cnt (saturating)
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 4,
  parameter int MODE    = BP_MODE_BIMODAL,
  parameter int STAT_W  = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lkp_valid,
  input  logic [31:0]       lkp_pc,
  output logic              lkp_taken,
  output logic [IDX_W-1:0]  lkp_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_pred,
  input  logic              clr,
  output logic [GHR_W-1:0]  ghr,
  output logic [STAT_W-1:0] mispred_cnt
);

  logic [ENTRIES-1:0][CTR_W-1:0] ctr;
  logic [GHR_W-1:0]              ghr_q, ghr_d;
  logic [STAT_W-1:0]             mis_q, mis_d;
  logic [IDX_W-1:0]              pc_idx;
  logic                          unused_pc;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr),
      .en_i    (upd_valid && (upd_idx == IDX_W'(g))),
      .taken_i (upd_taken),
      .ctr_o   (ctr[g])
    );
  end

  // Instructions are word aligned; the low two PC bits carry no information.
  assign pc_idx    = lkp_pc[IDX_W+1:2];
  assign unused_pc = ^{lkp_pc[31:IDX_W+2], lkp_pc[1:0]};

  if (MODE == BP_MODE_GSHARE) begin : g_gshare
    assign lkp_idx = pc_idx ^ IDX_W'(ghr_q);
  end else begin : g_bimodal
    assign lkp_idx = pc_idx;
  end

  // Reads registered state only, so a same-cycle update is not bypassed.
  assign lkp_taken = lkp_valid & ctr[lkp_idx][CTR_W-1];

  // Truncating the concatenation drops the oldest bit; works for GHR_W = 1 too.
  assign ghr_d = GHR_W'({ghr_q, upd_taken});
  assign mis_d = ((upd_pred != upd_taken) && (mis_q != '1)) ? mis_q + 1'b1 : mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
      mis_q <= '0;
    end else if (clr) begin
      ghr_q <= '0;
      mis_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= ghr_d;
      mis_q <= mis_d;
    end
  end

  assign ghr         = ghr_q;
  assign mispred_cnt = mis_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: a bimodal and a gshare instance share one
// stimulus stream; a table-of-integers model predicts both every cycle.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic        lkp_valid;
  logic [31:0] lkp_pc;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred;
  logic        clr;

  logic       b_taken, g_taken;
  logic [3:0] b_idx, g_idx, b_ghr, g_ghr, b_mis, g_mis;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int tbl [16];
  int mghr;
  int mmis;

  always #5 clk = ~clk;

  branch_predictor_bht #(.ENTRIES(16), .CTR_W(2), .GHR_W(4), .MODE(0), .STAT_W(4)) u_bim (
    .clk(clk), .rst(rst), .lkp_valid(lkp_valid), .lkp_pc(lkp_pc),
    .lkp_taken(b_taken), .lkp_idx(b_idx), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .clr(clr), .ghr(b_ghr), .mispred_cnt(b_mis));

  branch_predictor_bht #(.ENTRIES(16), .CTR_W(2), .GHR_W(4), .MODE(1), .STAT_W(4)) u_gsh (
    .clk(clk), .rst(rst), .lkp_valid(lkp_valid), .lkp_pc(lkp_pc),
    .lkp_taken(g_taken), .lkp_idx(g_idx), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .clr(clr), .ghr(g_ghr), .mispred_cnt(g_mis));

  // Model: counters are integers in 0..3, taken when in the upper half.
  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      for (int i = 0; i < 16; i++) tbl[i] <= 0;
      mghr <= 0;
      mmis <= 0;
    end else if (upd_valid) begin
      if (upd_taken) tbl[upd_idx] <= (tbl[upd_idx] < 3) ? tbl[upd_idx] + 1 : 3;
      else           tbl[upd_idx] <= (tbl[upd_idx] > 0) ? tbl[upd_idx] - 1 : 0;
      mghr <= (mghr * 2 + (upd_taken ? 1 : 0)) % 16;
      if (upd_pred != upd_taken && mmis < 15) mmis <= mmis + 1;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int pidx, gidx;
    pidx = (lkp_pc / 4) % 16;
    gidx = pidx ^ mghr;
    chk("bim_idx",   b_idx, pidx);
    chk("gsh_idx",   g_idx, gidx);
    chk("bim_taken", b_taken, (lkp_valid && tbl[pidx] >= 2) ? 1 : 0);
    chk("gsh_taken", g_taken, (lkp_valid && tbl[gidx] >= 2) ? 1 : 0);
    chk("bim_ghr",   b_ghr, mghr);
    chk("gsh_ghr",   g_ghr, mghr);
    chk("bim_mis",   b_mis, mmis);
    chk("gsh_mis",   g_mis, mmis);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; lkp_valid = 1'b1; lkp_pc = 32'h40;
    upd_valid = 1'b0; upd_idx = 4'd0; upd_taken = 1'b0; upd_pred = 1'b0; clr = 1'b0;
    #12 rst = 1'b0;
    tick();
    chk("lit_rst_taken", b_taken, 0);
    chk("lit_rst_ghr", b_ghr, 0);
    chk("lit_rst_mis", b_mis, 0);

    // Bimodal training on pc 0x40 -> idx 0.
    chk("lit_bim_idx40", b_idx, 0);
    upd_valid = 1'b1; upd_idx = 4'd0; upd_taken = 1'b1; upd_pred = 1'b1;
    tick();
    chk("lit_train1", b_taken, 0);
    tick();
    chk("lit_train2", b_taken, 1);
    repeat (5) tick();
    upd_taken = 1'b0; upd_pred = 1'b0;
    tick();
    upd_valid = 1'b0;
    #1;
    chk("lit_model_ctr0", tbl[0], 2);
    chk("lit_train_after_nt", b_taken, 1);

    // Gshare hash.
    clr = 1'b1; tick(); clr = 1'b0;
    upd_valid = 1'b1; upd_idx = 4'd5;
    upd_taken = 1'b1; upd_pred = 1'b1; tick();
    upd_taken = 1'b0; upd_pred = 1'b0; tick();
    upd_taken = 1'b1; upd_pred = 1'b1; tick();
    tick();
    upd_valid = 1'b0;
    chk("lit_ghr_1011", g_ghr, 4'hB);
    lkp_pc = 32'h40; #1;
    chk("lit_gidx_40", g_idx, 4'hB);
    lkp_pc = 32'h6C; #1;
    chk("lit_gidx_6c", g_idx, 4'h0);
    chk("lit_bidx_6c", b_idx, 4'hB);

    // Same-cycle lookup/update of entry 3: no bypass.
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    upd_valid = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1; upd_pred = 1'b1; tick();
    upd_valid = 1'b0; lkp_pc = 32'h0C; #1;
    chk("lit_haz_pre", b_taken, 0);
    tick();
    upd_valid = 1'b1; #1;
    chk("lit_haz_same", b_taken, 0);
    tick();
    upd_valid = 1'b0; #1;
    chk("lit_haz_next", b_taken, 1);

    // Mispredict saturation and clear.
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    lkp_pc = 32'h40;
    upd_valid = 1'b1; upd_idx = 4'd7;
    for (int i = 0; i < 17; i++) begin
      upd_taken = i[0]; upd_pred = ~i[0];
      tick();
    end
    chk("lit_mis_sat", b_mis, 15);
    chk("lit_mis_sat_g", g_mis, 15);
    clr = 1'b1; upd_taken = 1'b1; upd_pred = 1'b0; tick();
    clr = 1'b0; upd_valid = 1'b0;
    chk("lit_clr_mis", b_mis, 0);
    chk("lit_clr_ghr", g_ghr, 0);
    for (int i = 0; i < 16; i++) begin
      lkp_pc = 32'(i * 4); #1;
      chk("lit_clr_b", b_taken, 0);
      chk("lit_clr_g", g_taken, 0);
    end

    // Gating.
    tick();
    upd_valid = 1'b1; upd_idx = 4'd0; upd_taken = 1'b1; upd_pred = 1'b1;
    repeat (3) tick();
    upd_valid = 1'b0;
    lkp_valid = 1'b0; lkp_pc = 32'h40; #1;
    chk("lit_gate_lkp", b_taken, 0);
    lkp_valid = 1'b1; #1;
    chk("lit_gate_lkp_on", b_taken, 1);
    for (int i = 0; i < 6; i++) begin
      upd_idx = 4'($urandom_range(0, 15));
      upd_taken = i[0]; upd_pred = ~i[0];
      tick();
    end
    chk("lit_gate_ghr", b_ghr, 7);
    chk("lit_gate_mis", b_mis, 0);
    chk("lit_gate_taken", b_taken, 1);

    // Async reset mid-cycle with an update in flight.
    upd_valid = 1'b1; upd_idx = 4'd0; upd_taken = 1'b0; upd_pred = 1'b1;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      lkp_pc = 32'(i * 4); #1;
      chk("lit_arst_b", b_taken, 0);
      chk("lit_arst_g", g_taken, 0);
    end
    chk("lit_arst_ghr", b_ghr, 0);
    chk("lit_arst_mis", g_mis, 0);
    lkp_pc = 32'h40;
    @(negedge clk); #1;
    rst = 1'b0; upd_taken = 1'b1; upd_pred = 1'b1;
    tick();
    tick();
    upd_valid = 1'b0; #1;
    chk("lit_post_rst_taken", b_taken, 1);
    chk("lit_post_rst_ghr", b_ghr, 3);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised branch history table that replaces the single 2-bit predictor with an array of saturating counters. It runs in either bimodal (PC-indexed) or gshare (PC XOR global history) mode. It sits beside the ID-stage branch comparator. A combinational lookup gives the fetch/decode path a taken/not-taken prediction for a branch in the same cycle. A separate resolve port trains the table, advances the global history and counts mispredictions.

## Interface
- `ENTRIES`, 16: number of counters; power of two, ≥2; `IDX_W = log2(ENTRIES)`.
- `CTR_W`, 2: counter width, 1..4.
- `GHR_W`, 4: global history width, 1..`IDX_W`.
- `MODE`, 0: 0 = bimodal, 1 = gshare.
- `STAT_W`, 16: mispredict counter width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `lkp_valid`  in  1  a branch (Beq) is being predicted this cycle.
- `lkp_pc`  in  32  byte address of the branch.
- `lkp_taken`  out  1  prediction; combinational.
- `lkp_idx`  out  IDX_W  table index used; carried down the pipe with the branch.
- `upd_valid`  in  1  a branch resolved this cycle.
- `upd_idx`  in  IDX_W  index returned from lookup time.
- `upd_taken`  in  1  actual outcome (equal → taken).
- `upd_pred`  in  1  prediction made at lookup time.
- `clr`  in  1  synchronous table/history/stat clear.
- `ghr`  out  GHR_W  current global history, LSB = newest.
- `mispred_cnt`  out  STAT_W  saturating mispredict count.

## Operation
- Counter encoding: 0 = strong not-taken, `2^CTR_W-1` = strong taken. The prediction is the counter MSB.
- Index:
  - bimodal: `pc_idx = lkp_pc[IDX_W+1:2]`.
  - gshare: `pc_idx XOR {0, ghr}`, with ghr zero-extended to IDX_W.
- `lkp_idx` is always driven from `lkp_pc`.
- `lkp_taken = lkp_valid & ctr[lkp_idx][CTR_W-1]`. It is 0 when `lkp_valid` = 0.
- Update when `upd_valid` = 1:
  - `ctr[upd_idx]` increments if `upd_taken`, else decrements.
  - The counter saturates at both ends and never wraps.
- GHR when `upd_valid` = 1: `ghr <= {ghr[GHR_W-2:0], upd_taken}`. In bimodal mode it is still maintained, but it does not affect the index.
- Mispredict counter: when `upd_valid & (upd_pred != upd_taken)`, `mispred_cnt` increments. It saturates at all-ones.
- `clr` = 1 (sync) forces all counters, `ghr` and `mispred_cnt` to 0 and takes priority over `upd_valid` in the same cycle.
- `upd_*` is ignored when `upd_valid` = 0. `upd_pred`/`upd_taken` have no effect on the table except through `upd_valid`.

## Timing
- Reset (`rst` high, async): all counters = 0 (strong not-taken), `ghr` = 0, `mispred_cnt` = 0. `lkp_taken` = 0 immediately, and `lkp_idx` follows `lkp_pc`.
- Lookup latency: 0 cycles (combinational from `lkp_pc`, `lkp_valid` and registered state).
- Update latency: the counter, `ghr` and `mispred_cnt` change on the edge that samples `upd_valid`. They are visible to lookups in the following cycle.
- Simultaneous lookup and update of the same index: the lookup returns the pre-update value, with no bypass. In gshare mode the lookup also uses the pre-update `ghr`.
- Reset mid-operation: an asserted `rst` discards any update in flight. The update does not apply after release.
- The first update after `rst` deassertion is honoured on the first rising edge.
- No backpressure: at most one lookup and one update per cycle, always accepted.

## Structure
- Shared package `bp_pkg`: `BP_MODE_BIMODAL`/`BP_MODE_GSHARE` constants, the counter encoding comment and reset value (strong not-taken = 0), and function `bp_sat_next(ctr, taken)`.
- One natural sub-module, `bp_sat_ctr`: a single CTR_W-bit saturating counter with async reset, sync clear and enable. It is generated ENTRIES times.
- Index hashing, GHR and statistics stay in the top module.

## Test plan
- Reset: pulse `rst` mid-cycle with counters trained. → Immediately every `lkp_pc` with `lkp_valid` = 1 gives `lkp_taken` = 0, `ghr` = 0 and `mispred_cnt` = 0.
- Bimodal training (16/2/4, MODE=0), `lkp_pc` = 0x40 → `lkp_idx` = 0. Send two updates taken: `lkp_taken` goes 0 → 0 → 1. Send five more taken then one not-taken: the counter reads 2 and `lkp_taken` stays 1.
- Gshare hash (MODE=1): four updates with outcomes 1,0,1,1 → `ghr` = 4'b1011. A lookup of `lkp_pc` = 0x40 → `lkp_idx` = 4'hB. A lookup of `lkp_pc` = 0x6C → `lkp_idx` = 4'h0.
- Same-cycle hazard: entry 3 holds 1. Apply `lkp_pc` = 0x0C plus `upd_idx` = 3 with `upd_taken` = 1 in the same cycle → `lkp_taken` = 0 that cycle and 1 next cycle.
- Stats and clear (`STAT_W` = 4): 17 updates with `upd_pred` ≠ `upd_taken` → `mispred_cnt` = 15. Then `clr` together with `upd_valid` → the next cycle shows `mispred_cnt` = 0, `ghr` = 0 and all predictions 0.
- Gating: `lkp_valid` = 0 with entry 0 strongly taken → `lkp_taken` = 0. `upd_valid` = 0 with toggling `upd_*` → no state change.
